// File: rtl/ysyx_220053_mdu_seq.sv
// rtl/ysyx_220053_mdu_seq.sv - iterative RV64M multiply/divide sequencer
module ysyx_220053_mdu_seq #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

    state_t              state;
    logic [2*XLEN-1:0]   acc;
    logic [XLEN-1:0]     dsor;
    logic [6:0]          cnt;
    logic [2:0]          op_q;
    logic                word_q;
    logic                neg_res;
    logic                neg_rem;
    logic [XLEN-1:0]     result_q;
    logic                out_valid_q;

    logic                is_div;
    logic                mul_w;
    logic                sgn1;
    logic                sgn2;
    logic                neg1;
    logic                neg2;
    logic                div_zero;
    logic                div_ovf;
    logic [XLEN-1:0]     ext1;
    logic [XLEN-1:0]     ext2;
    logic [XLEN-1:0]     mag1;
    logic [XLEN-1:0]     mag2;
    logic [XLEN-1:0]     sext_src1;
    logic [XLEN-1:0]     spec_res;

    // Operand conditioning and special-case detection, evaluated while IDLE.
    always_comb begin
        is_div    = op[2];
        mul_w     = word & ~op[2];
        sgn1      = ~mul_w & (op == 3'b001 || op == 3'b010 || op == 3'b100 || op == 3'b110);
        sgn2      = ~mul_w & (op == 3'b001 || op == 3'b100 || op == 3'b110);
        ext1      = src1;
        ext2      = src2;
        if (word) begin
            ext1 = {{(XLEN-32){sgn1 & src1[31]}}, src1[31:0]};
            ext2 = {{(XLEN-32){sgn2 & src2[31]}}, src2[31:0]};
        end
        neg1      = sgn1 & ext1[XLEN-1];
        neg2      = sgn2 & ext2[XLEN-1];
        mag1      = neg1 ? -ext1 : ext1;
        mag2      = neg2 ? -ext2 : ext2;
        sext_src1 = word ? {{(XLEN-32){src1[31]}}, src1[31:0]} : src1;
        div_zero  = is_div && (word ? (src2[31:0] == 32'd0) : (src2 == '0));
        div_ovf   = is_div && !op[0] &&
                    (word ? (src1[31:0] == 32'h8000_0000 && src2[31:0] == 32'hFFFF_FFFF)
                          : (src1 == {1'b1, {(XLEN-1){1'b0}}} && src2 == '1));
        if (div_zero)
            spec_res = op[1] ? sext_src1 : '1;
        else
            spec_res = op[1] ? '0 : sext_src1;
    end

    logic [XLEN:0]       mul_sum;
    logic [XLEN+1:0]     div_diff;
    logic [2*XLEN-1:0]   acc_step;
    logic                unused_bits;

    // One radix-2 step: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, dsor};
        div_diff = {1'b0, acc[2*XLEN-1:XLEN-1]} - {2'b00, dsor};
        if (op_q[2]) begin
            if (!div_diff[XLEN+1])
                acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
                acc_step = {acc[2*XLEN-2:0], 1'b0};
        end else if (acc[0]) begin
            acc_step = {mul_sum, acc[XLEN-1:1]};
        end else begin
            acc_step = {1'b0, acc[2*XLEN-1:1]};
        end
    end

    assign unused_bits = div_diff[XLEN];

    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo;
    logic [XLEN-1:0]     rem;
    logic [XLEN-1:0]     fix_res;

    // A 32-iteration multiply leaves the product shifted up by 32 bits.
    always_comb begin
        prod = word_q ? {32'd0, acc[2*XLEN-1:32]} : acc;
        if (neg_res)
            prod = -prod;
        quo = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (!op_q[2])
            fix_res = (op_q == 3'b000 || word_q) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else if (!op_q[1])
            fix_res = quo;
        else
            fix_res = rem;
        if (word_q)
            fix_res = {{(XLEN-32){fix_res[31]}}, fix_res[31:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            dsor        <= '0;
            cnt         <= '0;
            op_q        <= '0;
            word_q      <= 1'b0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state       <= IDLE;
            cnt         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q    <= op;
                        word_q  <= word;
                        neg_res <= neg1 ^ neg2;
                        neg_rem <= neg1;
                        if (div_zero || div_ovf) begin
                            result_q    <= spec_res;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end else begin
                            // Word dividends start at bit 32 so 32 shifts consume them.
                            acc   <= (is_div && word) ? {{XLEN{1'b0}}, mag1[31:0], 32'd0}
                                                      : {{XLEN{1'b0}}, mag1};
                            dsor  <= mag2;
                            cnt   <= word ? 7'd32 : 7'd64;
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    acc <= acc_step;
                    cnt <= cnt - 7'd1;
                    if (cnt == 7'd1)
                        state <= FIX;
                end
                FIX: begin
                    result_q    <= fix_res;
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_ysyx_220053_mdu_seq.sv
// tb/tb_ysyx_220053_mdu_seq.sv - directed self-checking bench for the M-extension sequencer
module tb_ysyx_220053_mdu_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic        word;
    logic [63:0] src1;
    logic [63:0] src2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    ysyx_220053_mdu_seq #(.XLEN(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .word      (word),
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid && cyc < 200);
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int exp_cyc);
        int cyc;
        @(negedge clk);
        in_valid = 1'b1;
        op       = o;
        word     = w;
        src1     = a;
        src2     = b;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_valid(cyc);
        chk({tag, "_res"}, result, exp);
        chk({tag, "_cyc"}, 64'(cyc), 64'(exp_cyc));
        @(posedge clk);
        #1 chk({tag, "_rdy"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        int cyc;
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 3'b000;
        word      = 1'b0;
        src1      = '0;
        src2      = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_result", result, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("mulhu", 3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 66);
        run_op("mul",   3'b000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 66);
        run_op("div",   3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
        run_op("rem",   3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        run_op("mulhsu",3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        run_op("divu0", 3'b101, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("remu0", 3'b111, 1'b0, 64'h1234, 64'd0, 64'h1234, 1);
        run_op("divovf",3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
        run_op("removf",3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
        run_op("mulw",  3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34);
        run_op("divwov",3'b100, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
        run_op("divw",  3'b100, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34);

        // Backpressure: result held, new request waits until after the handshake.
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        op       = 3'b000;
        word     = 1'b0;
        src1     = 64'd3;
        src2     = 64'd5;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_valid(cyc);
        chk("bp_cyc", 64'(cyc), 64'd66);
        in_valid = 1'b1;
        src1     = 64'd6;
        src2     = 64'd7;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_result", result, 64'd15);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 chk("bp_rdy_after", {63'd0, in_ready}, 64'd1);
        chk("bp_valid_drop", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1 chk("bp_accept", {63'd0, busy}, 64'd1);
        in_valid = 1'b0;
        wait_valid(cyc);
        chk("bp_new_res", result, 64'd42);
        chk("bp_new_cyc", 64'(cyc), 64'd66);
        @(posedge clk);
        #1;

        // Flush at BUSY iteration 10.
        @(negedge clk);
        in_valid = 1'b1;
        src1     = 64'd9;
        src2     = 64'd9;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("fl_in_ready", {63'd0, in_ready}, 64'd1);
        chk("fl_busy", {63'd0, busy}, 64'd0);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("fl_no_valid", 64'(seen), 64'd0);

        // Flush together with a request blocks acceptance.
        @(negedge clk);
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flv_busy", {63'd0, busy}, 64'd0);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1;
        end
        chk("flv_idle", 64'(seen), 64'd0);

        // Asynchronous reset in the middle of BUSY.
        @(negedge clk);
        in_valid = 1'b1;
        src1     = 64'd11;
        src2     = 64'd13;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_in_ready", {63'd0, in_ready}, 64'd1);
        chk("ar_busy", {63'd0, busy}, 64'd0);
        chk("ar_out_valid", {63'd0, out_valid}, 64'd0);
        chk("ar_result", result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", 3'b000, 1'b0, 64'd3, 64'd5, 64'd15, 66);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
